// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage pipeline with a multi-cycle (mul/div) execution
// unit. It covers operand forwarding from EX/MEM/WB, load-use stalls,
// branch-redirect flushes, multi-cycle stalls with a timeout watchdog, and a
// saturating stall counter.
module hazard_unit_mc #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        src_re,
    input  logic [5*NSRC-1:0]      src_addr,
    input  logic                   ex_we,
    input  logic [4:0]             ex_wr,
    input  logic [XLEN-1:0]        ex_wd,
    input  logic                   ex_load,
    input  logic                   mem_we,
    input  logic [4:0]             mem_wr,
    input  logic [XLEN-1:0]        mem_wd,
    input  logic                   mem_load,
    input  logic                   wb_we,
    input  logic [4:0]             wb_wr,
    input  logic [XLEN-1:0]        wb_wd,
    input  logic                   redirect,
    input  logic                   mc_start,
    input  logic                   mc_done,
    output logic [NSRC-1:0]        fwd_hit,
    output logic [XLEN*NSRC-1:0]   fwd_data,
    output logic                   keep_pc,
    output logic                   keep_if_id,
    output logic                   keep_id_ex,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   flush_ex_mem,
    output logic                   mc_err,
    output logic [15:0]            stall_cnt
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit          LOAD2    = (LOAD_LAT == 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic               r_mc_err;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [NSRC-1:0]    w_match_ex;
    logic [NSRC-1:0]    w_match_mem;
    logic [NSRC-1:0]    w_match_wb;
    logic               w_lu;
    logic               w_timeout;
    logic               w_mcs;

    // Per-source stage matches and EX > MEM > WB forwarding mux.
    always_comb begin
        w_match_ex  = '0;
        w_match_mem = '0;
        w_match_wb  = '0;
        fwd_hit     = '0;
        fwd_data    = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            w_match_ex[i]  = src_re[i] & ex_we  & (ex_wr  == src_addr[5*i +: 5]) & (ex_wr  != 5'd0);
            w_match_mem[i] = src_re[i] & mem_we & (mem_wr == src_addr[5*i +: 5]) & (mem_wr != 5'd0);
            w_match_wb[i]  = src_re[i] & wb_we  & (wb_wr  == src_addr[5*i +: 5]) & (wb_wr  != 5'd0);
            fwd_hit[i]     = w_match_ex[i] | w_match_mem[i] | w_match_wb[i];
            if (w_match_ex[i]) begin
                fwd_data[XLEN*i +: XLEN] = ex_wd;
            end else if (w_match_mem[i]) begin
                fwd_data[XLEN*i +: XLEN] = mem_wd;
            end else if (w_match_wb[i]) begin
                fwd_data[XLEN*i +: XLEN] = wb_wd;
            end
        end
    end

    // Load-use detection; MEM-stage loads only matter for two-cycle load latency.
    always_comb begin
        w_lu = ((|w_match_ex) & ex_load) | (LOAD2 & (|w_match_mem) & mem_load);
    end

    // Multi-cycle stall request, masked once the watchdog expires.
    always_comb begin
        w_timeout = (r_state == ST_BUSY) & (r_timer == TMR_LAST);
        w_mcs     = mc_start & ~mc_done & ~w_timeout;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: enter BUSY on a stall, leave on completion or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mcs)                 w_state_nxt = ST_BUSY;
            ST_BUSY: if (mc_done | w_timeout)   w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    // Pipeline controls, priority mcs > redirect > load-use; all low in reset.
    always_comb begin
        keep_pc      = 1'b0;
        keep_if_id   = 1'b0;
        keep_id_ex   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (!rst) begin
            if (w_mcs) begin
                keep_pc      = 1'b1;
                keep_if_id   = 1'b1;
                keep_id_ex   = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (redirect) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (w_lu) begin
                keep_pc      = 1'b1;
                keep_if_id   = 1'b1;
                flush_id_ex  = 1'b1;
            end
        end
    end

    // Watchdog timer: cleared on entry to BUSY, counts while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if ((r_state == ST_IDLE) && w_mcs) begin
            r_timer <= '0;
        end else if (r_state == ST_BUSY) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mc_err <= 1'b0;
        end else if (w_timeout) begin
            r_mc_err <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (keep_pc && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mc_err    = r_mc_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: two instances (default parameters, and
// NSRC=3 / LOAD_LAT=2 / MC_TIMEOUT=8) share the same stimulus. A reference
// model predicts every cycle; a monitor pops and compares.
module tb_hazard_unit_mc;

    typedef struct packed {
        logic        rst;
        logic [2:0]  src_re;
        logic [14:0] src_addr;
        logic        ex_we;
        logic [4:0]  ex_wr;
        logic [31:0] ex_wd;
        logic        ex_load;
        logic        mem_we;
        logic [4:0]  mem_wr;
        logic [31:0] mem_wd;
        logic        mem_load;
        logic        wb_we;
        logic [4:0]  wb_wr;
        logic [31:0] wb_wd;
        logic        redirect;
        logic        mc_start;
        logic        mc_done;
    } stim_t;

    typedef struct packed {
        logic [2:0]  hit;
        logic [95:0] data;
        logic [5:0]  ctl;   // {keep_pc, keep_if_id, keep_id_ex, flush_if_id, flush_id_ex, flush_ex_mem}
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ex_we, ex_load, mem_we, mem_load, wb_we, redirect, mc_start, mc_done;
    logic [2:0]  src_re;
    logic [14:0] src_addr;
    logic [4:0]  ex_wr, mem_wr, wb_wr;
    logic [31:0] ex_wd, mem_wd, wb_wd;

    logic [1:0]  a_hit;
    logic [63:0] a_data;
    logic        a_kp, a_kif, a_kie, a_fif, a_fie, a_fem, a_err;
    logic [15:0] a_cnt;
    logic [2:0]  b_hit;
    logic [95:0] b_data;
    logic        b_kp, b_kif, b_kie, b_fif, b_fie, b_fem, b_err;
    logic [15:0] b_cnt;
    logic [5:0]  a_ctl, b_ctl;
    assign a_ctl = {a_kp, a_kif, a_kie, a_fif, a_fie, a_fem};
    assign b_ctl = {b_kp, b_kif, b_kie, b_fif, b_fie, b_fem};

    hazard_unit_mc dut_a (
        .clk(clk), .rst(rst), .src_re(src_re[1:0]), .src_addr(src_addr[9:0]),
        .ex_we(ex_we), .ex_wr(ex_wr), .ex_wd(ex_wd), .ex_load(ex_load),
        .mem_we(mem_we), .mem_wr(mem_wr), .mem_wd(mem_wd), .mem_load(mem_load),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd), .redirect(redirect),
        .mc_start(mc_start), .mc_done(mc_done), .fwd_hit(a_hit), .fwd_data(a_data),
        .keep_pc(a_kp), .keep_if_id(a_kif), .keep_id_ex(a_kie),
        .flush_if_id(a_fif), .flush_id_ex(a_fie), .flush_ex_mem(a_fem),
        .mc_err(a_err), .stall_cnt(a_cnt)
    );

    hazard_unit_mc #(.XLEN(32), .NSRC(3), .LOAD_LAT(2), .MC_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .src_re(src_re), .src_addr(src_addr),
        .ex_we(ex_we), .ex_wr(ex_wr), .ex_wd(ex_wd), .ex_load(ex_load),
        .mem_we(mem_we), .mem_wr(mem_wr), .mem_wd(mem_wd), .mem_load(mem_load),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd), .redirect(redirect),
        .mc_start(mc_start), .mc_done(mc_done), .fwd_hit(b_hit), .fwd_data(b_data),
        .keep_pc(b_kp), .keep_if_id(b_kif), .keep_id_ex(b_kie),
        .flush_if_id(b_fif), .flush_id_ex(b_fie), .flush_ex_mem(b_fem),
        .mc_err(b_err), .stall_cnt(b_cnt)
    );

    // Reference model state per instance: busy flag, cycles spent busy, sticky error, stall count.
    int m_nsrc [2] = '{2, 3};
    int m_ll   [2] = '{1, 2};
    int m_tmo  [2] = '{64, 8};
    bit m_busy [2];
    int m_age  [2];
    bit m_err  [2];
    int m_cnt  [2];

    exp_t  qa[$];
    exp_t  qb[$];
    stim_t st;
    bit    sb_on = 1'b0;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic bit model_timeout(int k);
        return m_busy[k] && (m_age[k] == m_tmo[k] - 1);
    endfunction

    function automatic exp_t model_out(int k, stim_t s);
        exp_t        e;
        logic        we_s [3];
        logic [4:0]  wr_s [3];
        logic [31:0] wd_s [3];
        logic [14:0] sa;
        logic [4:0]  a;
        bit          lu, mcs;
        e  = '0;
        sa = s.src_addr;
        we_s[0] = s.ex_we;  wr_s[0] = s.ex_wr;  wd_s[0] = s.ex_wd;
        we_s[1] = s.mem_we; wr_s[1] = s.mem_wr; wd_s[1] = s.mem_wd;
        we_s[2] = s.wb_we;  wr_s[2] = s.wb_wr;  wd_s[2] = s.wb_wd;
        lu = 1'b0;
        for (int i = 0; i < m_nsrc[k]; i++) begin
            a = sa[5*i +: 5];
            if (s.src_re[i] && a != 5'd0) begin
                for (int g = 2; g >= 0; g--) begin
                    if (we_s[g] && wr_s[g] == a) begin
                        e.hit[i] = 1'b1;
                        e.data[32*i +: 32] = wd_s[g];
                        if (g == 0 && s.ex_load) lu = 1'b1;
                        if (g == 1 && s.mem_load && m_ll[k] == 2) lu = 1'b1;
                    end
                end
            end
        end
        mcs = s.mc_start && !s.mc_done && !model_timeout(k);
        if (s.rst)           e.ctl = 6'b000000;
        else if (mcs)        e.ctl = 6'b111001;
        else if (s.redirect) e.ctl = 6'b000110;
        else if (lu)         e.ctl = 6'b110010;
        e.err = m_err[k];
        e.cnt = 16'(m_cnt[k]);
        return e;
    endfunction

    task automatic model_step(input int k, input stim_t s, input bit kp);
        bit tmo, mcs;
        tmo = model_timeout(k);
        mcs = s.mc_start && !s.mc_done && !tmo;
        if (s.rst) begin
            m_busy[k] = 1'b0; m_age[k] = 0; m_err[k] = 1'b0; m_cnt[k] = 0;
        end else begin
            if (kp && m_cnt[k] < 65535) m_cnt[k]++;
            if (!m_busy[k]) begin
                if (mcs) begin m_busy[k] = 1'b1; m_age[k] = 0; end
            end else begin
                if (tmo) m_err[k] = 1'b1;
                if (s.mc_done || tmo) m_busy[k] = 1'b0;
                else m_age[k]++;
            end
        end
    endtask

    // One cycle: drive at the falling edge, predict, queue the expectations.
    task automatic tick();
        exp_t ea, eb;
        @(negedge clk);
        cyc++;
        rst = st.rst; src_re = st.src_re; src_addr = st.src_addr;
        ex_we = st.ex_we; ex_wr = st.ex_wr; ex_wd = st.ex_wd; ex_load = st.ex_load;
        mem_we = st.mem_we; mem_wr = st.mem_wr; mem_wd = st.mem_wd; mem_load = st.mem_load;
        wb_we = st.wb_we; wb_wr = st.wb_wr; wb_wd = st.wb_wd;
        redirect = st.redirect; mc_start = st.mc_start; mc_done = st.mc_done;
        ea = model_out(0, st);
        eb = model_out(1, st);
        if (sb_on) begin
            qa.push_back(ea);
            qb.push_back(eb);
        end
        model_step(0, st, ea.ctl[5]);
        model_step(1, st, eb.ctl[5]);
    endtask

    // Monitor: sample mid-cycle and compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("A.fwd_hit",  128'({1'b0, a_hit}),   128'(e.hit));
                chk("A.fwd_data", 128'({32'd0, a_data}), 128'(e.data));
                chk("A.ctl",      128'(a_ctl),           128'(e.ctl));
                chk("A.mc_err",   128'(a_err),           128'(e.err));
                chk("A.stall_cnt",128'(a_cnt),           128'(e.cnt));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("B.fwd_hit",  128'(b_hit),  128'(e.hit));
                chk("B.fwd_data", 128'(b_data), 128'(e.data));
                chk("B.ctl",      128'(b_ctl),  128'(e.ctl));
                chk("B.mc_err",   128'(b_err),  128'(e.err));
                chk("B.stall_cnt",128'(b_cnt),  128'(e.cnt));
            end
        end
    end

    task automatic rand_stim();
        logic [14:0] sa;
        for (int i = 0; i < 3; i++) sa[5*i +: 5] = 5'($urandom_range(0, 7));
        st.rst      = ($urandom_range(0, 59) == 0);
        st.src_re   = 3'($urandom_range(0, 7));
        st.src_addr = sa;
        st.ex_we    = ($urandom_range(0, 3) != 0);
        st.ex_wr    = 5'($urandom_range(0, 7));
        st.ex_wd    = $urandom;
        st.ex_load  = ($urandom_range(0, 2) == 0);
        st.mem_we   = ($urandom_range(0, 3) != 0);
        st.mem_wr   = 5'($urandom_range(0, 7));
        st.mem_wd   = $urandom;
        st.mem_load = ($urandom_range(0, 2) == 0);
        st.wb_we    = ($urandom_range(0, 3) != 0);
        st.wb_wr    = 5'($urandom_range(0, 7));
        st.wb_wd    = $urandom;
        st.redirect = ($urandom_range(0, 7) == 0);
        if (st.mc_start) st.mc_start = ($urandom_range(0, 11) != 0);
        else             st.mc_start = ($urandom_range(0, 9) == 0);
        st.mc_done  = st.mc_start && ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        st = '0;
        st.rst = 1'b1;
        tick();
        sb_on = 1'b1;
        tick();                               // reset state is checked here
        st = '0;

        // Forwarding priority and x0 source
        st.src_re = 3'b011; st.src_addr = {5'd0, 5'd0, 5'd5};
        st.ex_we = 1'b1; st.ex_wr = 5'd5; st.ex_wd = 32'hA;
        st.mem_we = 1'b1; st.mem_wr = 5'd5; st.mem_wd = 32'hB;
        tick(); #3;
        chk("dir.fwd_hit",  128'(a_hit),  128'(2'b01));
        chk("dir.fwd_data", 128'(a_data), 128'(64'h0000_0000_0000_000A));

        // Load-use: one stall for LOAD_LAT=1, a second via MEM for LOAD_LAT=2
        st = '0;
        st.src_re = 3'b010; st.src_addr = {5'd0, 5'd7, 5'd0};
        st.ex_we = 1'b1; st.ex_wr = 5'd7; st.ex_load = 1'b1;
        tick(); #3;
        chk("dir.lu1.A", 128'(a_ctl), 128'(6'b110010));
        st.ex_we = 1'b0; st.ex_load = 1'b0;
        st.mem_we = 1'b1; st.mem_wr = 5'd7; st.mem_load = 1'b1;
        tick(); #3;
        chk("dir.lu2.A", 128'(a_ctl), 128'(6'b000000));
        chk("dir.lu2.B", 128'(b_ctl), 128'(6'b110010));

        // Load-use together with redirect
        st.mem_we = 1'b0; st.mem_load = 1'b0;
        st.ex_we = 1'b1; st.ex_load = 1'b1; st.redirect = 1'b1;
        tick(); #3;
        chk("dir.redir", 128'(a_ctl), 128'(6'b000110));

        // Multi-cycle op completing after 4 stall cycles
        st = '0; st.rst = 1'b1; tick();
        st = '0; st.mc_start = 1'b1;
        repeat (4) tick();
        st.mc_done = 1'b1; tick();
        st = '0; tick(); #3;
        chk("dir.mc.cntA", 128'(a_cnt), 128'(16'd4));
        chk("dir.mc.cntB", 128'(b_cnt), 128'(16'd4));

        // Timeout on instance B (MC_TIMEOUT=8)
        st.mc_start = 1'b1;
        repeat (9) tick();
        st = '0; tick(); #3;
        chk("dir.tmo.err", 128'(b_err), 128'(1'b1));
        chk("dir.tmo.cnt", 128'(b_cnt), 128'(16'd12));
        repeat (3) tick();
        st.mc_start = 1'b1;
        repeat (3) tick();
        st = '0; st.rst = 1'b1; tick();
        st = '0; tick(); #3;
        chk("dir.rst.err", 128'(b_err), 128'(1'b0));

        // Randomised traffic
        repeat (3000) begin
            rand_stim();
            tick();
        end

        st = '0;
        tick();
        repeat (3) @(negedge clk);
        #4;
        chk("queue.A.drained", 128'(qa.size()), 128'(0));
        chk("queue.B.drained", 128'(qb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of forwarded values.
REQ-002 SHALL have parameter NSRC, default 2 (legal 1..3), number of ID-stage source operands.
REQ-003 SHALL have parameter LOAD_LAT, default 1 (legal 1..2), load-use stall depth in cycles.
REQ-004 SHALL have parameter MC_TIMEOUT, default 64 (legal 2..255), maximum cycles for a multi-cycle op.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port src_re  in  NSRC  per-source read enable in ID.
REQ-008 SHALL have port src_addr  in  5*NSRC  per-source register index, source i at bits [5i+4:5i].
REQ-009 SHALL have ports ex_we  in  1,  ex_wr  in  5,  ex_wd  in  XLEN: EX-stage write enable, destination, result.
REQ-010 SHALL have port ex_load  in  1  EX instruction is a load.
REQ-011 SHALL have ports mem_we  in  1,  mem_wr  in  5,  mem_wd  in  XLEN: MEM-stage write enable, destination, result.
REQ-012 SHALL have port mem_load  in  1  MEM instruction is a load.
REQ-013 SHALL have ports wb_we  in  1,  wb_wr  in  5,  wb_wd  in  XLEN: WB-stage write enable, destination, data.
REQ-014 SHALL have port redirect  in  1  EX branch/jump taken; PC loads target.
REQ-015 SHALL have port mc_start  in  1  EX holds a multi-cycle (mul/div) op.
REQ-016 SHALL have port mc_done  in  1  multi-cycle result valid this cycle.
REQ-017 SHALL have port fwd_hit  out  NSRC  per-source forward select.
REQ-018 SHALL have port fwd_data  out  XLEN*NSRC  per-source forwarded value.
REQ-019 SHALL have ports keep_pc, keep_if_id, keep_id_ex  out  1 each: hold the register.
REQ-020 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem  out  1 each: insert a bubble.
REQ-021 SHALL have port mc_err  out  1  sticky multi-cycle timeout flag.
REQ-022 SHALL have port stall_cnt  out  16  saturating count of cycles with keep_pc=1.

Function
REQ-023 SHALL set match(i,S) = src_re[i] & S_we & (S_wr == src i index) & (S_wr != 0) for S in {EX, MEM, WB}.
REQ-024 SHALL forward by priority EX > MEM > WB: fwd_hit[i] = any match, fwd_data[i] = the selected stage's data, else 0; purely combinational.
REQ-025 SHALL raise load-use (lu) when any match(i,EX) & ex_load, or (LOAD_LAT==2 and any match(i,MEM) & mem_load).
REQ-026 SHALL implement FSM states IDLE and BUSY plus an 8-bit timer; mcs (mc stall) = mc_start & ~mc_done & ~timeout, where timeout = BUSY & (timer == MC_TIMEOUT-1).
REQ-027 SHALL transition IDLE->BUSY on mcs, clearing timer; in BUSY timer increments each cycle.
REQ-028 SHALL transition BUSY->IDLE on mc_done or timeout; on timeout it SHALL set mc_err, which only rst clears.
REQ-029 SHALL apply priority mcs > redirect > lu: on mcs, keep_pc = keep_if_id = keep_id_ex = flush_ex_mem = 1, all other controls 0.
REQ-030 SHALL, on redirect without mcs, set flush_if_id = flush_id_ex = 1 and keep_pc = 0, suppressing lu (the ID instruction is wrong-path).
REQ-031 SHALL, on lu alone, set keep_pc = keep_if_id = flush_id_ex = 1.
REQ-032 SHALL drive all keep/flush outputs to 0 when no condition holds; mc_start & mc_done in the same IDLE cycle causes no stall.
REQ-033 SHALL increment stall_cnt by 1 each cycle keep_pc=1, holding at 16'hFFFF.

Reset
REQ-034 SHALL, while rst=1, at each clock edge set state=IDLE, timer=0, mc_err=0, stall_cnt=0, and force all keep/flush outputs to 0 combinationally.
REQ-035 SHALL abandon a BUSY op on rst mid-operation without setting mc_err.

Verification
REQ-036 SHALL show: ex_we=1, ex_wr=5, ex_wd=0xA, mem_wr=5, mem_wd=0xB, src0=x5 -> fwd_hit[0]=1, fwd_data=0xA; x0 source -> fwd_hit=0, fwd_data=0.
REQ-037 SHALL show: ex_load=1 to x7, src1=x7 -> one cycle keep_pc=keep_if_id=flush_id_ex=1; with LOAD_LAT=2 -> a second cycle via mem_load.
REQ-038 SHALL show: lu and redirect in the same cycle -> flush_if_id=flush_id_ex=1, keep_pc=0.
REQ-039 SHALL show: mc_start held, mc_done after 4 cycles -> 4 stall cycles, flush_ex_mem=1 each, IDLE after done, stall_cnt=4.
REQ-040 SHALL show: MC_TIMEOUT=8, mc_done never asserted -> stall ends after 8 cycles, mc_err=1 until rst; rst during BUSY -> IDLE, mc_err=0.
